// File: rtl/pipe_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_unit_pkg
// Purpose  : Shared types and constants for the pipeline hazard/forwarding unit
// Revision : 1.0 - initial release
// ============================================================================
package pipe_hazard_unit_pkg;

    localparam int ENTRY_RA_W = 5;

    // Forward-select value meaning "take the operand from the register file"
    localparam int FWD_SEL_RF = 0;

    localparam int EXE = 1;
    localparam int MEM = 2;
    localparam int WB  = 3;

    typedef struct packed {
        logic                  v;
        logic [ENTRY_RA_W-1:0] dr;
        logic                  wen;
        logic                  ld;
    } hazard_entry_t;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_unit_src_match.sv
`default_nettype none
// ============================================================================
// Module   : hazard_src_match
// Purpose  : Youngest-match search and load-readiness check for one source
// Revision : 1.0 - initial release
// ============================================================================
module hazard_src_match
    import pipe_hazard_unit_pkg::*;
#(
    parameter int NUM_STAGES       = 3,
    parameter int RA_W             = 5,
    parameter int LOAD_READY_STAGE = 2,
    parameter int FWD_EN           = 1,
    parameter int SEL_W            = $clog2(NUM_STAGES + 1)
) (
    input  logic                     live,
    input  logic [RA_W-1:0]          rs,
    input  logic [NUM_STAGES-1:0]    ent_v,
    input  logic [NUM_STAGES-1:0]    ent_wen,
    input  logic [NUM_STAGES-1:0]    ent_ld,
    input  logic [NUM_STAGES*RA_W-1:0] ent_dr,
    output logic                     stall,
    output logic [SEL_W-1:0]         sel
);

    logic             w_hit;
    logic             w_hit_ld;
    logic [SEL_W-1:0] w_hit_k;

    // Scan oldest to youngest so the youngest match is the one left standing
    always_comb begin
        w_hit    = 1'b0;
        w_hit_ld = 1'b0;
        w_hit_k  = '0;
        for (int k = NUM_STAGES; k >= 1; k--) begin
            if (ent_v[k-1] && ent_wen[k-1] && (ent_dr[(k-1)*RA_W +: RA_W] == rs)) begin
                w_hit    = 1'b1;
                w_hit_ld = ent_ld[k-1];
                w_hit_k  = SEL_W'(k);
            end
        end
    end

    always_comb begin
        stall = 1'b0;
        sel   = SEL_W'(FWD_SEL_RF);
        if (live && w_hit) begin
            if (FWD_EN == 0) begin
                stall = 1'b1;
            end else if (w_hit_ld && (int'(w_hit_k) < LOAD_READY_STAGE)) begin
                stall = 1'b1;
            end else begin
                sel = w_hit_k;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_unit
// Purpose  : In-flight destination tracking, operand forwarding, load-use
//            stall, redirect flush and saturating stall counter
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int XLEN             = 64,
    parameter int NUM_STAGES       = 3,
    parameter int RA_W             = 5,
    parameter int LOAD_READY_STAGE = 2,
    parameter int BR_STAGE         = 1,
    parameter int FWD_EN           = 1,
    parameter int SEL_W            = $clog2(NUM_STAGES + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       de_v,
    input  logic [RA_W-1:0]            de_rs1,
    input  logic [RA_W-1:0]            de_rs2,
    input  logic                       de_use_rs1,
    input  logic                       de_use_rs2,
    input  logic [RA_W-1:0]            de_dr,
    input  logic                       de_wen,
    input  logic                       de_is_load,
    input  logic [NUM_STAGES*XLEN-1:0] stage_res,
    input  logic                       br_taken,
    output logic                       stall,
    output logic                       flush,
    output logic [SEL_W-1:0]           fwd_rs1_sel,
    output logic [SEL_W-1:0]           fwd_rs2_sel,
    output logic [XLEN-1:0]            fwd_rs1_data,
    output logic [XLEN-1:0]            fwd_rs2_data,
    output logic [NUM_STAGES-1:0]      inflight_v,
    output logic [31:0]                stall_cnt
);

    hazard_entry_t r_entry [NUM_STAGES];
    logic [31:0]   r_stall_cnt;

    logic [NUM_STAGES-1:0]      w_v;
    logic [NUM_STAGES-1:0]      w_wen;
    logic [NUM_STAGES-1:0]      w_ld;
    logic [NUM_STAGES*RA_W-1:0] w_dr;
    logic                       w_s1_stall;
    logic                       w_s2_stall;
    logic [SEL_W-1:0]           w_s1_sel;
    logic [SEL_W-1:0]           w_s2_sel;
    logic                       w_live1;
    logic                       w_live2;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_flat
        assign w_v[k]                 = r_entry[k].v;
        assign w_wen[k]               = r_entry[k].wen;
        assign w_ld[k]                = r_entry[k].ld;
        assign w_dr[k*RA_W +: RA_W]   = RA_W'(r_entry[k].dr);
    end

    assign w_live1 = de_v & de_use_rs1 & (de_rs1 != '0);
    assign w_live2 = de_v & de_use_rs2 & (de_rs2 != '0);

    hazard_src_match #(
        .NUM_STAGES       (NUM_STAGES),
        .RA_W             (RA_W),
        .LOAD_READY_STAGE (LOAD_READY_STAGE),
        .FWD_EN           (FWD_EN),
        .SEL_W            (SEL_W)
    ) u_src1 (
        .live    (w_live1),
        .rs      (de_rs1),
        .ent_v   (w_v),
        .ent_wen (w_wen),
        .ent_ld  (w_ld),
        .ent_dr  (w_dr),
        .stall   (w_s1_stall),
        .sel     (w_s1_sel)
    );

    hazard_src_match #(
        .NUM_STAGES       (NUM_STAGES),
        .RA_W             (RA_W),
        .LOAD_READY_STAGE (LOAD_READY_STAGE),
        .FWD_EN           (FWD_EN),
        .SEL_W            (SEL_W)
    ) u_src2 (
        .live    (w_live2),
        .rs      (de_rs2),
        .ent_v   (w_v),
        .ent_wen (w_wen),
        .ent_ld  (w_ld),
        .ent_dr  (w_dr),
        .stall   (w_s2_stall),
        .sel     (w_s2_sel)
    );

    assign flush       = br_taken;
    assign stall       = (w_s1_stall | w_s2_stall) & ~flush;
    assign fwd_rs1_sel = stall ? SEL_W'(FWD_SEL_RF) : w_s1_sel;
    assign fwd_rs2_sel = stall ? SEL_W'(FWD_SEL_RF) : w_s2_sel;
    assign inflight_v  = w_v;
    assign stall_cnt   = r_stall_cnt;

    always_comb begin
        fwd_rs1_data = '0;
        fwd_rs2_data = '0;
        for (int k = 1; k <= NUM_STAGES; k++) begin
            if (fwd_rs1_sel == SEL_W'(k)) fwd_rs1_data = stage_res[(k-1)*XLEN +: XLEN];
            if (fwd_rs2_sel == SEL_W'(k)) fwd_rs2_data = stage_res[(k-1)*XLEN +: XLEN];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_STAGES; k++) r_entry[k] <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_entry[0].v   <= de_v & ~stall & ~flush;
            r_entry[0].dr  <= ENTRY_RA_W'(de_dr);
            r_entry[0].wen <= de_wen & (de_dr != '0);
            r_entry[0].ld  <= de_is_load;
            // Stages younger than the redirecting one are wrong-path work
            for (int k = 1; k < NUM_STAGES; k++) begin
                r_entry[k] <= r_entry[k-1];
                if (flush && (k < BR_STAGE)) r_entry[k].v <= 1'b0;
            end
            if (stall && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_unit
// Purpose  : Directed self-checking bench for pipe_hazard_unit
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_unit;

    localparam int XLEN = 64;
    localparam int NS   = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            de_v = 1'b0;
    logic [4:0]      de_rs1 = '0, de_rs2 = '0, de_dr = '0;
    logic            de_use_rs1 = 1'b0, de_use_rs2 = 1'b0;
    logic            de_wen = 1'b0, de_is_load = 1'b0;
    logic            br_taken = 1'b0;
    logic [NS*XLEN-1:0] stage_res = {64'hC0DE_0003, 64'hBEEF_0002, 64'h0000_1234};

    logic            stall, flush;
    logic [1:0]      s1, s2;
    logic [XLEN-1:0] d1, d2;
    logic [NS-1:0]   inflight;
    logic [31:0]     cnt;

    logic            l_stall, l_flush;
    logic [1:0]      l_s1, l_s2;
    logic [XLEN-1:0] l_d1, l_d2;
    logic [NS-1:0]   l_inflight;
    logic [31:0]     l_cnt;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit #(.BR_STAGE(2)) dut (
        .clk(clk), .rst_n(rst_n), .de_v(de_v), .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2), .de_dr(de_dr), .de_wen(de_wen),
        .de_is_load(de_is_load), .stage_res(stage_res), .br_taken(br_taken),
        .stall(stall), .flush(flush), .fwd_rs1_sel(s1), .fwd_rs2_sel(s2),
        .fwd_rs1_data(d1), .fwd_rs2_data(d2), .inflight_v(inflight), .stall_cnt(cnt)
    );

    pipe_hazard_unit #(.FWD_EN(0)) dut_leg (
        .clk(clk), .rst_n(rst_n), .de_v(de_v), .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2), .de_dr(de_dr), .de_wen(de_wen),
        .de_is_load(de_is_load), .stage_res(stage_res), .br_taken(br_taken),
        .stall(l_stall), .flush(l_flush), .fwd_rs1_sel(l_s1), .fwd_rs2_sel(l_s2),
        .fwd_rs1_data(l_d1), .fwd_rs2_data(l_d2), .inflight_v(l_inflight), .stall_cnt(l_cnt)
    );

    task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2,
                         input logic [4:0] d, input logic w, input logic l);
        de_v = v; de_rs1 = r1; de_use_rs1 = u1; de_rs2 = r2; de_use_rs2 = u2;
        de_dr = d; de_wen = w; de_is_load = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        br_taken = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        #3;
        checks++; if (stall !== 1'b0) $display("FAIL rst_stall: got %0b want 0", stall); else passes++;
        checks++; if (flush !== 1'b0) $display("FAIL rst_flush: got %0b want 0", flush); else passes++;
        checks++; if (inflight !== 3'b000) $display("FAIL rst_inflight: got %b want 000", inflight); else passes++;
        checks++; if (cnt !== 32'd0) $display("FAIL rst_cnt: got %h want 0", cnt); else passes++;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if ({s1, s2, d1, d2} !== '0) $display("FAIL rst_after_sel_data: got %h want 0", {s1, s2, d1, d2}); else passes++;
        checks++; if (stall !== 1'b0) $display("FAIL rst_after_stall: got %0b want 0", stall); else passes++;
    endtask

    task automatic test_back_to_back();
        drain();
        drive(1, 0, 0, 0, 0, 5, 1, 0);
        tick();
        drive(1, 5, 1, 0, 0, 6, 1, 0);
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL b2b_stall: got %0b want 0", stall); else passes++;
        checks++; if (s1 !== 2'd1) $display("FAIL b2b_sel: got %0d want 1", s1); else passes++;
        checks++; if (d1 !== 64'h1234) $display("FAIL b2b_data: got %h want 1234", d1); else passes++;
        checks++; if (inflight !== 3'b001) $display("FAIL b2b_inflight: got %b want 001", inflight); else passes++;
        tick();
    endtask

    task automatic test_load_use();
        drain();
        drive(1, 0, 0, 0, 0, 7, 1, 1);
        tick();
        drive(1, 0, 0, 7, 1, 8, 1, 0);
        #1;
        checks++; if (stall !== 1'b1) $display("FAIL lu_stall: got %0b want 1", stall); else passes++;
        checks++; if (s2 !== 2'd0 || d2 !== 64'd0) $display("FAIL lu_sel_while_stall: got %0d/%h want 0/0", s2, d2); else passes++;
        tick();
        checks++; if (stall !== 1'b0) $display("FAIL lu_stall_release: got %0b want 0", stall); else passes++;
        checks++; if (cnt !== 32'd1) $display("FAIL lu_cnt: got %0d want 1", cnt); else passes++;
        checks++; if (s2 !== 2'd2) $display("FAIL lu_sel: got %0d want 2", s2); else passes++;
        checks++; if (d2 !== 64'hBEEF_0002) $display("FAIL lu_data: got %h want beef0002", d2); else passes++;
        tick();
    endtask

    task automatic test_shadow();
        drain();
        drive(1, 0, 0, 0, 0, 3, 1, 0); tick();
        drive(1, 0, 0, 0, 0, 4, 1, 0); tick();
        drive(1, 0, 0, 0, 0, 3, 1, 0); tick();
        drive(1, 3, 1, 4, 1, 9, 0, 0);
        #1;
        checks++; if (s1 !== 2'd1) $display("FAIL shadow_sel: got %0d want 1", s1); else passes++;
        checks++; if (d1 !== 64'h1234) $display("FAIL shadow_data: got %h want 1234", d1); else passes++;
        checks++; if (s2 !== 2'd2) $display("FAIL shadow_mem_sel: got %0d want 2", s2); else passes++;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 4, 1, 0, 0, 9, 0, 0);
        #1;
        checks++; if (s1 !== 2'd3 || d1 !== 64'hC0DE_0003) $display("FAIL wb_fwd: got %0d/%h want 3/c0de0003", s1, d1); else passes++;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 4, 1, 0, 0, 9, 0, 0);
        #1;
        checks++; if (s1 !== 2'd0 || d1 !== 64'd0) $display("FAIL shifted_out: got %0d/%h want 0/0", s1, d1); else passes++;
        drain();
        drive(1, 0, 0, 0, 0, 0, 1, 0); tick();
        drive(1, 0, 1, 0, 1, 9, 0, 0);
        #1;
        checks++; if ({stall, s1, s2} !== 5'b0) $display("FAIL x0_dep: got %b want 00000", {stall, s1, s2}); else passes++;
        tick();
    endtask

    task automatic test_flush();
        drain();
        drive(1, 0, 0, 0, 0, 10, 1, 0); tick();
        drive(1, 0, 0, 0, 0, 7, 1, 1); tick();
        drive(1, 0, 0, 7, 1, 11, 1, 0);
        #1;
        checks++; if (stall !== 1'b1) $display("FAIL fl_pre_stall: got %0b want 1", stall); else passes++;
        br_taken = 1'b1;
        #1;
        checks++; if (flush !== 1'b1 || stall !== 1'b0) $display("FAIL fl_prio: got flush=%0b stall=%0b want 1/0", flush, stall); else passes++;
        tick();
        br_taken = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (inflight !== 3'b100) $display("FAIL fl_inflight: got %b want 100", inflight); else passes++;
        checks++; if (cnt !== 32'd1) $display("FAIL fl_cnt: got %0d want 1", cnt); else passes++;
        drive(1, 10, 1, 0, 0, 0, 0, 0);
        #1;
        checks++; if (s1 !== 2'd3) $display("FAIL fl_survivor_sel: got %0d want 3", s1); else passes++;
    endtask

    task automatic test_legacy();
        drain();
        drive(1, 0, 0, 0, 0, 12, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);  tick();
        drive(1, 12, 1, 0, 0, 13, 1, 0);
        #1;
        checks++; if (l_stall !== 1'b1 || l_s1 !== 2'd0) $display("FAIL leg_c1: got stall=%0b sel=%0d want 1/0", l_stall, l_s1); else passes++;
        tick();
        checks++; if (l_stall !== 1'b1 || l_s1 !== 2'd0) $display("FAIL leg_c2: got stall=%0b sel=%0d want 1/0", l_stall, l_s1); else passes++;
        tick();
        checks++; if (l_stall !== 1'b0 || l_s1 !== 2'd0) $display("FAIL leg_c3: got stall=%0b sel=%0d want 0/0", l_stall, l_s1); else passes++;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        drain();
        drive(1, 0, 0, 0, 0, 7, 1, 1); tick();
        drive(1, 0, 0, 7, 1, 8, 1, 0);
        #1;
        checks++; if (stall !== 1'b1) $display("FAIL rms_pre: got %0b want 1", stall); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || inflight !== 3'b000) $display("FAIL rms_async: got stall=%0b inflight=%b want 0/000", stall, inflight); else passes++;
        checks++; if (cnt !== 32'd0) $display("FAIL rms_cnt: got %0d want 0", cnt); else passes++;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_saturation();
        drain();
        force dut_leg.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut_leg.r_stall_cnt;
        drive(1, 0, 0, 0, 0, 12, 1, 0); tick();
        drive(1, 12, 1, 0, 0, 13, 1, 0);
        #1;
        checks++; if (l_cnt !== 32'hFFFF_FFFE) $display("FAIL sat_start: got %h want fffffffe", l_cnt); else passes++;
        tick();
        checks++; if (l_cnt !== 32'hFFFF_FFFF) $display("FAIL sat_c1: got %h want ffffffff", l_cnt); else passes++;
        tick();
        tick();
        checks++; if (l_cnt !== 32'hFFFF_FFFF || l_stall !== 1'b0) $display("FAIL sat_hold: got %h stall=%0b want ffffffff/0", l_cnt, l_stall); else passes++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_shadow();
        test_flush();
        test_legacy();
        test_reset_mid_stall();
        test_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
